// File: rtl/execute_pkg.sv
// Shared widths and the writeback-queue entry layout for the execute/WB boundary.
package execute_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DR_W_DEF   = 3;

    // Entry layout at default widths; the queue re-declares it at its own widths.
    typedef struct packed {
        logic                  v;
        logic [DATA_W_DEF-1:0] result;
        logic [DATA_W_DEF-1:0] flags;
        logic [DR_W_DEF-1:0]   dr;
        logic                  ld_gpr1;
        logic                  repne;
    } wb_entry_t;

endpackage

// File: rtl/execute_wb_queue_ptr.sv
// Circular-buffer pointer that wraps from DEPTH-1 to 0 (DEPTH need not be a power of two).
module execute_wb_queue_ptr #(
    parameter int DEPTH = 2,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/execute_wb_queue.sv
// EX->WB completion queue: buffers DEPTH uops, squashes REPNE iterations, feeds the dependency checker.
// Optional forwarding outputs are built when EXECUTE_WB_QUEUE_FWD_EN is defined.
module execute_wb_queue
    import execute_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2,
    parameter int DR_W   = DR_W_DEF
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       EX_V,
    input  logic [DATA_W-1:0]          EX_RESULT_A,
    input  logic [DATA_W-1:0]          EX_FLAGS,
    input  logic [DR_W-1:0]            EX_DR1,
    input  logic                       EX_ld_gpr1,
    input  logic                       EX_repne,
    input  logic                       WB_stall,
    input  logic                       wb_repne_terminate_all,
    input  logic [DR_W-1:0]            DEP_query_dr,
    output logic                       EX_stall,
    output logic                       WB_V,
    output logic [DATA_W-1:0]          WB_RESULT_A,
    output logic [DATA_W-1:0]          WB_FLAGS,
    output logic [DR_W-1:0]            WB_DR1,
    output logic                       WB_ld_gpr1,
    output logic                       WB_repne,
    output logic                       DEP_query_hit,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef EXECUTE_WB_QUEUE_FWD_EN
    ,
    output logic                       DEP_fwd_valid,
    output logic [DATA_W-1:0]          DEP_fwd_data
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] flags;
        logic [DR_W-1:0]   dr;
        logic              ld_gpr1;
        logic              repne;
    } entry_t;

    entry_t           slots [DEPTH];
    logic [OCC_W-1:0] occ;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             head_occ, push, pop;
    entry_t           head;

    assign head     = slots[rd_ptr];
    assign head_occ = (occ != '0);
    assign EX_stall = (occ == OCC_W'(DEPTH));
    assign push     = EX_V & ~EX_stall & ~(wb_repne_terminate_all & EX_repne);
    assign pop      = head_occ & (~head.v | ~WB_stall);

    execute_wb_queue_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .CLK(CLK), .CLR(CLR), .inc(pop),  .ptr(rd_ptr)
    );
    execute_wb_queue_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .CLK(CLK), .CLR(CLR), .inc(push), .ptr(wr_ptr)
    );

    // v is cleared on pop, so v=1 always implies the slot is occupied.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++)
                slots[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wb_repne_terminate_all && slots[i].repne)
                    slots[i].v <= 1'b0;
            if (pop)
                slots[rd_ptr].v <= 1'b0;
            if (push)
                slots[wr_ptr] <= '{v: 1'b1, result: EX_RESULT_A, flags: EX_FLAGS,
                                   dr: EX_DR1, ld_gpr1: EX_ld_gpr1, repne: EX_repne};
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)
            occ <= '0;
        else if (push && !pop)
            occ <= occ + 1'b1;
        else if (pop && !push)
            occ <= occ - 1'b1;
    end

    assign occupancy   = occ;
    assign WB_V        = head_occ & head.v;
    assign WB_RESULT_A = head.result;
    assign WB_FLAGS    = head.flags;
    assign WB_DR1      = head.dr;
    assign WB_ld_gpr1  = WB_V & head.ld_gpr1;
    assign WB_repne    = head.repne;

    always_comb begin
        DEP_query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (slots[i].v && slots[i].ld_gpr1 && (slots[i].dr == DEP_query_dr))
                DEP_query_hit = 1'b1;
    end

`ifdef EXECUTE_WB_QUEUE_FWD_EN
    logic [PW-1:0] scan_p;

    // Walk oldest to youngest from rd_ptr; the last match seen is the youngest.
    always_comb begin
        scan_p       = rd_ptr;
        DEP_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slots[scan_p].v && slots[scan_p].ld_gpr1 && (slots[scan_p].dr == DEP_query_dr))
                DEP_fwd_data = slots[scan_p].result;
            scan_p = (scan_p == PW'(DEPTH - 1)) ? '0 : scan_p + 1'b1;
        end
    end

    assign DEP_fwd_valid = DEP_query_hit;
`else
    // No forwarding network: dependent uops wait for the value to reach WB.
`endif

endmodule

// File: doc/execute_wb_queue.md
Name: execute_wb_queue

Overview:
- Parametrised successor to the single EX->WB latch with its stall/bubble logic.
- Sits between the execute functional units and writeback; buffers up to DEPTH completed uops so execute can keep issuing while WB stalls.
- Squashes in-flight REPNE iterations when WB signals termination.
- Exports queue-resident register-write information to the dependency checker.

Parameters:
- DATA_W, 32, width of result and flags fields.
- DEPTH, 2, number of buffered entries (>=1, need not be a power of two).
- DR_W, 3, destination register index width.

Ports:
- CLK  in  1  clock, all state on rising edge.
- CLR  in  1  asynchronous active-high reset.
- EX_V  in  1  execute uop valid.
- EX_RESULT_A  in  DATA_W  result to write back.
- EX_FLAGS  in  DATA_W  flags result.
- EX_DR1  in  DR_W  destination register.
- EX_ld_gpr1  in  1  uop writes EX_DR1.
- EX_repne  in  1  uop is a REPNE iteration.
- WB_stall  in  1  writeback cannot accept head this cycle.
- wb_repne_terminate_all  in  1  squash all queued REPNE iterations.
- DEP_query_dr  in  DR_W  register probed by the dependency checker.
- EX_stall  out  1  queue full; execute must hold.
- WB_V  out  1  head entry valid.
- WB_RESULT_A  out  DATA_W  head result.
- WB_FLAGS  out  DATA_W  head flags.
- WB_DR1  out  DR_W  head destination.
- WB_ld_gpr1  out  1  head writes WB_DR1, gated by WB_V.
- WB_repne  out  1  head is a REPNE iteration.
- DEP_query_hit  out  1  some valid entry has ld_gpr1=1 and dr==DEP_query_dr.
- occupancy  out  $clog2(DEPTH+1)  occupied slot count.

Behaviour:
- Storage: circular buffer of DEPTH slots.
  - Per slot: v, result, flags, dr, ld_gpr1, repne.
  - Pointers wr_ptr and rd_ptr wrap explicitly from DEPTH-1 to 0.
  - occupancy counts slots, including squashed bubbles.
- Reset (CLR high, async): pointers=0, occupancy=0, all slot v=0.
  - Outputs during reset: EX_stall=0, WB_V=0, WB_ld_gpr1=0, DEP_query_hit=0.
  - Data outputs are don't-care.
  - Reset mid-operation discards every entry; no partial pops.
- EX_stall = (occupancy==DEPTH). It is registered-state only and has no combinational path from WB_stall. A full queue stalls execute for one cycle even if WB pops that cycle.
- push = EX_V & ~EX_stall & ~(wb_repne_terminate_all & EX_repne).
  - A pushed entry is written at wr_ptr with v=1.
  - It is visible at the WB outputs no earlier than the next cycle; minimum latency is 1.
- Head is occupied when occupancy>0. WB_V = head occupied & head.v.
- pop = head occupied & (~head.v | ~WB_stall). Squashed bubbles drain one per cycle regardless of WB_stall.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. Push into a full queue is impossible (EX_stall). Pop from empty is impossible.
- Terminate (wb_repne_terminate_all=1): every occupied slot with repne=1 gets v=0 at the clock edge.
  - Exception: the head being popped that same cycle completes its pop normally.
  - Non-REPNE entries are untouched and order is preserved.
  - The EX uop with EX_repne=1 in the same cycle is dropped and not pushed.
- DEP_query_hit is combinational over valid occupied slots only. Squashed slots never hit.
- DEPTH=1 degenerates to the legacy single latch plus a one-cycle bubble after full.

Optional Feature:
- EXECUTE_WB_QUEUE_FWD_EN defined: adds outputs DEP_fwd_valid (1) and DEP_fwd_data (DATA_W).
  - They give the result of the youngest valid entry matching DEP_query_dr with ld_gpr1=1.
  - Youngest means nearest to wr_ptr going backwards.
  - DEP_fwd_valid equals DEP_query_hit.
- Undefined: the ports are absent, no priority search logic is built, and dependent uops must wait for WB.

Decomposition:
- Shared package (execute_pkg): default widths DATA_W_DEF=32 and DR_W_DEF=3, plus the queue-entry struct/typedef (v, result, flags, dr, ld_gpr1, repne).
- One natural sub-module: execute_wb_queue_ptr, a wrap-at-DEPTH pointer/increment unit instantiated for rd_ptr and wr_ptr.

Test Plan:
- Reset with CLR=1 mid-fill, 2 entries held: WB_V=0 and occupancy=0 immediately and asynchronously; after release, push A=0x11 -> next cycle WB_RESULT_A=0x11, WB_V=1.
- DEPTH=2, WB_stall=1, push 0xA, 0xB -> occupancy=2, EX_stall=1. Release stall -> 0xA then 0xB on consecutive cycles. EX_stall stays 1 in the first pop cycle and 0 after.
- Simultaneous push and pop at occupancy=1: occupancy stays 1, order preserved. 0x1,0x2,0x3 streamed with WB_stall=0 emerge in order, one per cycle.
- Queue holds [nonrep 0x5, rep 0x6], WB_stall=1, terminate=1 with EX_repne=1 -> EX uop dropped, 0x6 squashed. WB presents 0x5, then bubble drains with WB_V=0, occupancy goes 2->1->0.
- Entries dr=3 ld=1 and dr=3 ld=0: query 3 -> hit=1. Query 4 -> hit=0. After the dr=3 ld=1 entry pops -> hit=0.
- FWD_EN, two entries both dr=2 ld=1 with results 0x10 (older) and 0x20 -> DEP_fwd_data=0x20. Older entry still returns 0x20 until the younger pops.
